// File: rtl/hazard_pkg.sv
// Shared types and helpers for the decode-stage hazard controller.
package hazard_pkg;

  // Reason the decode stage is held or cleared this cycle.
  typedef enum logic [1:0] {
    HZ_NONE    = 2'd0,
    HZ_LOADUSE = 2'd1,
    HZ_SCORE   = 2'd2,
    HZ_FLUSH   = 2'd3
  } hz_cause_e;

  // Largest supported MUL latency; the countdown must hold this value.
  localparam int MUL_LAT_MAX = 15;

  // Bits needed for a countdown that starts at lat and ends at zero.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/EX pipeline signals consumed and pipeline controls produced by the hazard controller.
interface hazard_scoreboard_if #(
  parameter int REG_AW   = 4,
  parameter int STALL_CW = 16
);
  logic [REG_AW-1:0]   IFIDRegRs;
  logic [REG_AW-1:0]   IFIDRegRt;
  logic                IFIDUsesRs;
  logic                IFIDUsesRt;
  logic [REG_AW-1:0]   IFIDRegRd;
  logic                IFIDWritesRd;
  logic                IFIDIsMul;
  logic [REG_AW-1:0]   IDEXRegRt;
  logic                IDEXMemRead;
  logic                BranchTaken;
  logic                PCWrite;
  logic                IFIDWrite;
  logic                IDEXBubble;
  logic                IFIDFlush;
  logic [1:0]          HazardCause;
  logic [STALL_CW-1:0] StallCount;

  // Pipeline side: presents decode/EX state, receives the controls.
  modport master (
    output IFIDRegRs, IFIDRegRt, IFIDUsesRs, IFIDUsesRt, IFIDRegRd,
           IFIDWritesRd, IFIDIsMul, IDEXRegRt, IDEXMemRead, BranchTaken,
    input  PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, HazardCause, StallCount
  );

  // Controller side.
  modport slave (
    input  IFIDRegRs, IFIDRegRt, IFIDUsesRs, IFIDUsesRt, IFIDRegRd,
           IFIDWritesRd, IFIDIsMul, IDEXRegRt, IDEXMemRead, BranchTaken,
    output PCWrite, IFIDWrite, IDEXBubble, IFIDFlush, HazardCause, StallCount
  );
endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: counts down the cycles until a pending MUL result is forwardable.
module hazard_sb_entry #(
  parameter int MUL_LAT = 3,
  parameter int CW      = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);
  logic [CW-1:0] cnt;

  // A fresh issue restarts the countdown; otherwise drain towards zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(MUL_LAT);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall/flush controller: load-use detection, MUL scoreboard,
// branch flush priority and a saturating stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int MUL_LAT  = 3,
  parameter bit ZERO_REG = 1'b1,
  parameter int STALL_CW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_scoreboard_if.slave hz
);
  localparam int NREG = 2 ** REG_AW;
  localparam int CW   = cnt_width(MUL_LAT);

  logic [NREG-1:0]     busy;
  logic [NREG-1:0]     load;
  logic                load_use;
  logic                sb_hit;
  logic                issue;
  hz_cause_e           cause;
  logic                pc_write;
  logic                ifid_write;
  logic                idex_bubble;
  logic                ifid_flush;
  logic [STALL_CW-1:0] stall_count;

  // A register participates in hazards unless it is the hardwired zero.
  function automatic logic reg_match(input logic [REG_AW-1:0] r);
    return (r != '0) || !ZERO_REG;
  endfunction

  // Only a MUL that actually leaves decode this cycle claims its destination.
  assign issue = rst_n && (cause == HZ_NONE) && hz.IFIDIsMul && hz.IFIDWritesRd;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_sb
      assign load[gi] = issue && (hz.IFIDRegRd == REG_AW'(gi)) && (!ZERO_REG || (gi != 0));
      hazard_sb_entry #(.MUL_LAT(MUL_LAT), .CW(CW)) u_entry (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load[gi]),
        .busy (busy[gi])
      );
    end
  endgenerate

  // Detect the two stall sources from the current decode/EX contents.
  always_comb begin
    load_use = hz.IDEXMemRead && reg_match(hz.IDEXRegRt) &&
               ((hz.IFIDUsesRs && (hz.IFIDRegRs == hz.IDEXRegRt)) ||
                (hz.IFIDUsesRt && (hz.IFIDRegRt == hz.IDEXRegRt)));
    sb_hit   = (hz.IFIDUsesRs   && busy[hz.IFIDRegRs]) ||
               (hz.IFIDUsesRt   && busy[hz.IFIDRegRt]) ||
               (hz.IFIDWritesRd && busy[hz.IFIDRegRd]);
  end

  // Priority: reset hold, then flush, then load-use, then scoreboard.
  always_comb begin
    cause       = HZ_NONE;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!rst_n) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (hz.BranchTaken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      cause       = HZ_FLUSH;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      cause       = HZ_LOADUSE;
    end else if (sb_hit) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      cause       = HZ_SCORE;
    end
  end

  // Count stall cycles (not flushes), sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (((cause == HZ_LOADUSE) || (cause == HZ_SCORE)) &&
                 (stall_count != {STALL_CW{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign hz.PCWrite     = pc_write;
  assign hz.IFIDWrite   = ifid_write;
  assign hz.IDEXBubble  = idex_bubble;
  assign hz.IFIDFlush   = ifid_flush;
  assign hz.HazardCause = cause;
  assign hz.StallCount  = stall_count;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomised + directed bench for hazard_scoreboard; two instances
// (ZERO_REG=1/STALL_CW=4 and ZERO_REG=0/STALL_CW=16) driven identically.
module tb_hazard_scoreboard;
  localparam int LAT = 3;

  typedef struct {
    bit         rst_n;
    logic [3:0] rs, rt, rd, idex_rt;
    bit         uses_rs, uses_rt, writes_rd, is_mul, memread, branch;
  } stim_t;

  typedef struct packed {
    bit         pcw;
    bit         ifidw;
    bit         bubble;
    bit         flush;
    bit [1:0]   cause;
    logic [31:0] stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(4), .STALL_CW(4))  ifa ();
  hazard_scoreboard_if #(.REG_AW(4), .STALL_CW(16)) ifb ();

  hazard_scoreboard #(.REG_AW(4), .MUL_LAT(LAT), .ZERO_REG(1'b1), .STALL_CW(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .hz(ifa));
  hazard_scoreboard #(.REG_AW(4), .MUL_LAT(LAT), .ZERO_REG(1'b0), .STALL_CW(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .hz(ifb));

  // Reference state: the cycle number from which each register is free again.
  longint cyc = 0;
  longint ready_at [2][16];
  longint stalls [2];
  exp_t   q0 [$];
  exp_t   q1 [$];
  int     errors = 0;
  int     checks = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '{rst_n: 1'b1, rs: 4'd0, rt: 4'd0, rd: 4'd0, idex_rt: 4'd0,
          uses_rs: 1'b0, uses_rt: 1'b0, writes_rd: 1'b0, is_mul: 1'b0,
          memread: 1'b0, branch: 1'b0};
    return s;
  endfunction

  function automatic bit matters(int m, logic [3:0] r);
    return (r != 4'd0) || (m == 1);
  endfunction

  function automatic bit pending(int m, logic [3:0] r);
    return cyc < ready_at[m][r];
  endfunction

  // Expected controls for this cycle, then advance the reference to the next cycle.
  function automatic exp_t model(int m, stim_t s);
    exp_t   e;
    bit     lu;
    bit     sb;
    longint smax;
    smax = (m == 0) ? 15 : 65535;
    if (!s.rst_n) begin
      for (int r = 0; r < 16; r++) ready_at[m][r] = 0;
      stalls[m] = 0;
      e = '{pcw: 1'b0, ifidw: 1'b0, bubble: 1'b1, flush: 1'b0, cause: 2'd0, stall: 32'd0};
      return e;
    end
    lu = s.memread && matters(m, s.idex_rt) &&
         ((s.uses_rs && s.rs == s.idex_rt) || (s.uses_rt && s.rt == s.idex_rt));
    sb = (s.uses_rs && pending(m, s.rs)) || (s.uses_rt && pending(m, s.rt)) ||
         (s.writes_rd && pending(m, s.rd));
    e.stall = 32'(stalls[m]);
    if (s.branch)  e = '{pcw: 1'b1, ifidw: 1'b1, bubble: 1'b1, flush: 1'b1, cause: 2'd3, stall: e.stall};
    else if (lu)   e = '{pcw: 1'b0, ifidw: 1'b0, bubble: 1'b1, flush: 1'b0, cause: 2'd1, stall: e.stall};
    else if (sb)   e = '{pcw: 1'b0, ifidw: 1'b0, bubble: 1'b1, flush: 1'b0, cause: 2'd2, stall: e.stall};
    else           e = '{pcw: 1'b1, ifidw: 1'b1, bubble: 1'b0, flush: 1'b0, cause: 2'd0, stall: e.stall};
    if (e.cause == 2'd0 && s.is_mul && s.writes_rd && matters(m, s.rd))
      ready_at[m][s.rd] = cyc + LAT + 1;
    if ((e.cause == 2'd1 || e.cause == 2'd2) && stalls[m] < smax)
      stalls[m] = stalls[m] + 1;
    return e;
  endfunction

  task automatic step(input stim_t s);
    @(negedge clk);
    rst_n = s.rst_n;
    ifa.IFIDRegRs = s.rs;        ifb.IFIDRegRs = s.rs;
    ifa.IFIDRegRt = s.rt;        ifb.IFIDRegRt = s.rt;
    ifa.IFIDUsesRs = s.uses_rs;  ifb.IFIDUsesRs = s.uses_rs;
    ifa.IFIDUsesRt = s.uses_rt;  ifb.IFIDUsesRt = s.uses_rt;
    ifa.IFIDRegRd = s.rd;        ifb.IFIDRegRd = s.rd;
    ifa.IFIDWritesRd = s.writes_rd; ifb.IFIDWritesRd = s.writes_rd;
    ifa.IFIDIsMul = s.is_mul;    ifb.IFIDIsMul = s.is_mul;
    ifa.IDEXRegRt = s.idex_rt;   ifb.IDEXRegRt = s.idex_rt;
    ifa.IDEXMemRead = s.memread; ifb.IDEXMemRead = s.memread;
    ifa.BranchTaken = s.branch;  ifb.BranchTaken = s.branch;
    q0.push_back(model(0, s));
    q1.push_back(model(1, s));
    cyc++;
  endtask

  task automatic compare(input string name, input exp_t act, input exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got pc=%0b ifid=%0b bub=%0b fl=%0b cause=%0d stall=%0d, want pc=%0b ifid=%0b bub=%0b fl=%0b cause=%0d stall=%0d",
               name, cyc - 1, act.pcw, act.ifidw, act.bubble, act.flush, act.cause, act.stall,
               exp.pcw, exp.ifidw, exp.bubble, exp.flush, exp.cause, exp.stall);
    end else begin
      $display("ok   %s cyc=%0d cause=%0d stall=%0d", name, cyc - 1, act.cause, act.stall);
    end
  endtask

  // Monitor: every cycle the DUTs present controls; pop and compare mid-cycle.
  initial begin
    exp_t act;
    forever begin
      @(negedge clk);
      #3;
      if (q0.size() > 0) begin
        act = '{pcw: ifa.PCWrite, ifidw: ifa.IFIDWrite, bubble: ifa.IDEXBubble,
                flush: ifa.IFIDFlush, cause: ifa.HazardCause, stall: 32'(ifa.StallCount)};
        compare("dut_a", act, q0.pop_front());
      end
      if (q1.size() > 0) begin
        act = '{pcw: ifb.PCWrite, ifidw: ifb.IFIDWrite, bubble: ifb.IDEXBubble,
                flush: ifb.IFIDFlush, cause: ifb.HazardCause, stall: 32'(ifb.StallCount)};
        compare("dut_b", act, q1.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    for (int m = 0; m < 2; m++) begin
      stalls[m] = 0;
      for (int r = 0; r < 16; r++) ready_at[m][r] = 0;
    end

    // Reset, then quiet pipeline.
    s = idle(); s.rst_n = 1'b0;
    step(s); step(s);
    step(idle());

    // Load-use on r5, then the same with the source not read.
    s = idle(); s.memread = 1'b1; s.idex_rt = 4'd5; s.rs = 4'd5; s.uses_rs = 1'b1;
    step(s);
    step(idle());
    s.uses_rs = 1'b0;
    step(s);

    // Load-use on r0: ignored by the zero-register instance only.
    s = idle(); s.memread = 1'b1; s.idex_rt = 4'd0; s.rt = 4'd0; s.uses_rt = 1'b1;
    step(s);

    // MUL r7 then a consumer of r7: held three cycles, advances on the fourth.
    s = idle(); s.is_mul = 1'b1; s.writes_rd = 1'b1; s.rd = 4'd7;
    step(s);
    s = idle(); s.rs = 4'd7; s.uses_rs = 1'b1;
    repeat (4) step(s);

    // WAW on r2.
    s = idle(); s.is_mul = 1'b1; s.writes_rd = 1'b1; s.rd = 4'd2;
    step(s);
    s = idle(); s.writes_rd = 1'b1; s.rd = 4'd2;
    repeat (4) step(s);

    // Flush with a MUL in decode: no scoreboard claim, so r9 is free next cycle.
    s = idle(); s.branch = 1'b1; s.is_mul = 1'b1; s.writes_rd = 1'b1; s.rd = 4'd9;
    step(s);
    s = idle(); s.rt = 4'd9; s.uses_rt = 1'b1;
    step(s);

    // A flush after issue leaves the pending MUL in place.
    s = idle(); s.is_mul = 1'b1; s.writes_rd = 1'b1; s.rd = 4'd4;
    step(s);
    s = idle(); s.branch = 1'b1;
    step(s);
    s = idle(); s.rs = 4'd4; s.uses_rs = 1'b1;
    repeat (3) step(s);

    // Reset mid-countdown clears the scoreboard.
    s = idle(); s.is_mul = 1'b1; s.writes_rd = 1'b1; s.rd = 4'd6;
    step(s);
    s = idle(); s.rs = 4'd6; s.uses_rs = 1'b1;
    step(s);
    s.rst_n = 1'b0;
    step(s);
    s.rst_n = 1'b1;
    step(s);

    // Twenty stall cycles: 4-bit counter sticks at 15, 16-bit one reads 19 on the last.
    s = idle(); s.memread = 1'b1; s.idex_rt = 4'd3; s.rs = 4'd3; s.uses_rs = 1'b1;
    repeat (20) step(s);
    #4;
    checks++;
    if (ifa.StallCount !== 4'd15) begin
      errors++;
      $display("FAIL sat_a got=%0d want=15", ifa.StallCount);
    end
    checks++;
    if (ifb.StallCount !== 16'd19) begin
      errors++;
      $display("FAIL sat_b got=%0d want=19", ifb.StallCount);
    end

    // Random traffic over a small register set so hazards are frequent.
    for (int i = 0; i < 600; i++) begin
      s.rst_n     = ($urandom_range(99) != 0);
      s.rs        = 4'($urandom_range(7));
      s.rt        = 4'($urandom_range(7));
      s.rd        = 4'($urandom_range(7));
      s.idex_rt   = 4'($urandom_range(7));
      s.uses_rs   = 1'($urandom_range(1));
      s.uses_rt   = 1'($urandom_range(1));
      s.writes_rd = 1'($urandom_range(1));
      s.is_mul    = ($urandom_range(3) == 0);
      s.memread   = ($urandom_range(3) == 0);
      s.branch    = ($urandom_range(9) == 0);
      step(s);
    end

    #6;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d/%0d left want=0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
